example_mul_share_arb: RTL and testbench
========================================

// Module: example_mul_share_arb
// PURPOSE
//  Shares one signed-14 x unsigned-6 DSP48 multiplier between NUM_REQ requesters.
//  - Round-robin grant; valid/ready handshake per requester.
//  - Fixed-latency pipeline; single tagged response channel with backpressure.
//  - Sits between HLS dataflow stages that each need an occasional 14x6 product.
// PARAMETERS
//  NUM_REQ  4   number of requesters, 2..8
//  A_W      14  operand a width, signed
//  B_W      6   operand b width, unsigned (zero-extended before multiply)
//  P_W      20  product width = A_W+B_W, full precision, no truncation
//  LAT      2   accept-to-rsp_valid latency in cycles, legal 1..3
//  ID_W     $clog2(NUM_REQ), min 1; requester tag width
// PORTS
//  ap_clk     in   1            clock, all logic on rising edge
//  ap_rst     in   1            synchronous reset, active-high
//  req_valid  in   NUM_REQ      per-requester operand valid
//  req_ready  out  NUM_REQ      per-requester accept, one-hot or zero
//  req_a      in   NUM_REQ*A_W  packed a operands, requester i at [i*A_W +: A_W]
//  req_b      in   NUM_REQ*B_W  packed b operands, requester i at [i*B_W +: B_W]
//  rsp_valid  out  1            product valid
//  rsp_ready  in   1            downstream accept
//  rsp_p      out  P_W          signed product
//  rsp_id     out  ID_W         index of the requester that issued the product
//  busy       out  1            any operation in flight or rsp_valid high
// BEHAVIOUR
//  - Reset: rsp_valid=0, rsp_p=0, rsp_id=0, busy=0, all stage valids=0, rr_ptr=0.
//    Reset mid-operation drops every in-flight op; no response for it ever appears.
//  - Stall: stall = rsp_valid & ~rsp_ready. While stalled, all pipeline stages hold
//    and req_ready=0. rsp_p and rsp_id stay stable until the handshake.
//  - Arbitration (combinational, no stall):
//    - Pick the first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//    - Assert req_ready[i] only for that i; all req_ready=0 if no req_valid or stall.
//    - rr_ptr <= (i+1) mod NUM_REQ on a grant; unchanged otherwise.
//  - Transfer occurs on req_valid[i] & req_ready[i].
//    - Stage 1 registers a, b and the id.
//    - The product appears at rsp_* exactly LAT cycles after the transfer when there
//      is no stall; each stall cycle adds one cycle.
//  - Throughput: one accept per cycle; no bubbles while rsp_ready=1.
//  - Arithmetic: rsp_p = $signed(a) * $signed({1'b0,b}), P_W bits, exact.
//  - Ordering: responses leave in grant order. Each accepted op yields exactly one
//    response; none is lost or duplicated.
//  - Requester rule: once req_valid[i] is raised it must stay high, with stable
//    operands, until req_ready[i]. The bench asserts this; the RTL does not check it.
//  - busy = OR of the stage valids and rsp_valid.
// CONFIGURATION
//  MUL_SHARE_STATS_EN defined:
//    - Adds input stat_clr (1) and output stat_cnt (NUM_REQ*16).
//    - Holds a 16-bit saturating grant counter per requester, +1 per transfer.
//    - Counters stick at 0xFFFF.
//    - stat_clr or ap_rst zeroes them; stat_clr wins over a same-cycle grant.
//  MUL_SHARE_STATS_EN undefined: these ports and counters do not exist; all other
//    behaviour is identical.
// STRUCTURE
//  - Shared package example_mul_share_pkg:
//    - constants A_W, B_W, P_W, default LAT;
//    - typedef mul_req_t {a, b, id};
//    - typedef mul_rsp_t {p, id}.
//  - Sub-module example_mul_share_dsp:
//    - LAT-stage registered signed x zero-extended-unsigned multiply with enable (~stall);
//    - carries id and valid alongside the operands.
//  - This file holds the arbiter, rr_ptr, stall logic and optional counters.
// TESTING
//  1. req0 only, a=-8192, b=63 -> req_ready[0] same cycle; LAT cycles later
//     rsp_valid=1, rsp_p=20'h82000 (-516096), rsp_id=0.
//  2. req3 only, a=8191, b=63 -> rsp_p=20'h7DFC1 (516033), rsp_id=3; and a=-1, b=0
//     -> rsp_p=0.
//  3. All four req_valid held high for 8 cycles from reset, rsp_ready=1
//     -> grant order 0,1,2,3,0,1,2,3; 8 responses on consecutive cycles.
//  4. Continuous traffic, rsp_ready=0 for 5 cycles -> req_ready=0 and rsp_p/rsp_id
//     frozen during the stall; after release, no lost or duplicated products.
//  5. Two ops in flight, ap_rst for 1 cycle -> next cycle rsp_valid=0, busy=0,
//     rr_ptr=0; no stale response after release.
//  6. (MUL_SHARE_STATS_EN) 3 grants to req2 -> stat_cnt[2]=3; stat_clr with a
//     simultaneous grant -> 0.

Source files
------------

// File: rtl/example_mul_share_pkg.sv
// Shared types and constants for the shared 14x6 multiplier block.
// Operand widths are fixed; the pipeline latency default lives here so the
// top and its DSP stage agree on it.
package example_mul_share_pkg;

    localparam int A_W         = 14;
    localparam int B_W         = 6;
    localparam int P_W         = A_W + B_W;
    localparam int LAT_DEFAULT = 2;
    localparam int MAX_REQ     = 8;
    localparam int MAX_ID_W    = 3;

    typedef struct packed {
        logic [A_W-1:0]      a;
        logic [B_W-1:0]      b;
        logic [MAX_ID_W-1:0] id;
    } mul_req_t;

    typedef struct packed {
        logic [P_W-1:0]      p;
        logic [MAX_ID_W-1:0] id;
    } mul_rsp_t;

    // Tag width for a given requester count, never below one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/example_mul_share_arb_if.sv
// Request/response bus of the shared multiplier.
// master = requester side (bench or upstream stages), slave = the arbiter.
interface example_mul_share_arb_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = example_mul_share_pkg::id_width(NUM_REQ);

    logic [NUM_REQ-1:0]                            req_valid;
    logic [NUM_REQ-1:0]                            req_ready;
    logic [NUM_REQ*example_mul_share_pkg::A_W-1:0] req_a;
    logic [NUM_REQ*example_mul_share_pkg::B_W-1:0] req_b;
    logic                                          rsp_valid;
    logic                                          rsp_ready;
    logic [example_mul_share_pkg::P_W-1:0]         rsp_p;
    logic [ID_W-1:0]                               rsp_id;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_p, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_p, rsp_id
    );

endinterface

// File: rtl/example_mul_share_dsp.sv
// LAT-stage signed x zero-extended-unsigned multiply pipeline.
// Stage 1 registers the operands and tag; the product is formed from the
// stage-1 registers and carried through any remaining stages. The whole
// pipeline freezes when en is low so the output holds under backpressure.
module example_mul_share_dsp
    import example_mul_share_pkg::*;
#(
    parameter int LAT  = LAT_DEFAULT,
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            in_valid,
    input  logic [A_W-1:0]  in_a,
    input  logic [B_W-1:0]  in_b,
    input  logic [ID_W-1:0] in_id,
    output logic            out_valid,
    output logic [P_W-1:0]  out_p,
    output logic [ID_W-1:0] out_id,
    output logic            any_valid
);

    logic [LAT-1:0]        vld_q;
    logic [ID_W-1:0]       id_q [LAT];
    logic [A_W-1:0]        a_q;
    logic [B_W-1:0]        b_q;
    logic signed [P_W-1:0] a_ext;
    logic signed [P_W-1:0] b_ext;
    logic signed [P_W-1:0] prod;

    // Stage 1 captures operands; valid and tag shift through every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            for (int s = 0; s < LAT; s++) begin
                id_q[s] <= '0;
            end
        end else if (en) begin
            vld_q[0] <= in_valid;
            id_q[0]  <= in_id;
            a_q      <= in_a;
            b_q      <= in_b;
            for (int s = 1; s < LAT; s++) begin
                vld_q[s] <= vld_q[s-1];
                id_q[s]  <= id_q[s-1];
            end
        end
    end

    // a is sign-extended, b zero-extended, so the 20-bit product is exact.
    assign a_ext = {{(P_W-A_W){a_q[A_W-1]}}, a_q};
    assign b_ext = {{(P_W-B_W){1'b0}}, b_q};
    assign prod  = a_ext * b_ext;

    generate
        if (LAT == 1) begin : g_lat1
            assign out_p = prod;
        end else begin : g_latn
            logic [P_W-1:0] p_q [LAT-1];

            // Product stages after the operand register.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < LAT-1; s++) begin
                        p_q[s] <= '0;
                    end
                end else if (en) begin
                    p_q[0] <= prod;
                    for (int s = 1; s < LAT-1; s++) begin
                        p_q[s] <= p_q[s-1];
                    end
                end
            end

            assign out_p = p_q[LAT-2];
        end
    endgenerate

    assign out_valid = vld_q[LAT-1];
    assign out_id    = id_q[LAT-1];
    assign any_valid = |vld_q;

endmodule

// File: rtl/example_mul_share_arb.sv
// Round-robin front end sharing one 14x6 multiplier among NUM_REQ requesters.
// Holds the grant pointer, the stall logic and the optional grant counters.
// Optional feature: define MUL_SHARE_STATS_EN to add stat_clr/stat_cnt and
// per-requester 16-bit saturating grant counters.
module example_mul_share_arb
    import example_mul_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LAT     = LAT_DEFAULT
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    example_mul_share_arb_if.slave bus,
`ifdef MUL_SHARE_STATS_EN
    input  logic                   stat_clr,
    output logic [NUM_REQ*16-1:0]  stat_cnt,
`endif
    output logic                   busy
);

    localparam int ID_W = id_width(NUM_REQ);

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] next_ptr;
    logic            grant_found;
    logic            stall;
    logic            take;
    logic [A_W-1:0]  sel_a;
    logic [B_W-1:0]  sel_b;

    assign stall = bus.rsp_valid & ~bus.rsp_ready;
    assign take  = grant_found & ~stall;

    // Search from rr_ptr upward, then wrap to the indices below it.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        sel_a       = '0;
        sel_b       = '0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!grant_found && bus.req_valid[i] &&
                    ((pass == 0) == (ID_W'(i) >= rr_ptr))) begin
                    grant_found = 1'b1;
                    grant_idx   = ID_W'(i);
                    sel_a       = bus.req_a[i*A_W +: A_W];
                    sel_b       = bus.req_b[i*B_W +: B_W];
                end
            end
        end
    end

    // One-hot ready for the winner, nothing while the output is stalled.
    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (take && grant_idx == ID_W'(i)) begin
                bus.req_ready[i] = 1'b1;
            end
        end
    end

    assign next_ptr = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

    // Pointer moves just past the winner on every accepted request.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            rr_ptr <= '0;
        end else if (take) begin
            rr_ptr <= next_ptr;
        end
    end

    example_mul_share_dsp #(
        .LAT  (LAT),
        .ID_W (ID_W)
    ) u_dsp (
        .clk       (ap_clk),
        .rst       (ap_rst),
        .en        (~stall),
        .in_valid  (take),
        .in_a      (sel_a),
        .in_b      (sel_b),
        .in_id     (grant_idx),
        .out_valid (bus.rsp_valid),
        .out_p     (bus.rsp_p),
        .out_id    (bus.rsp_id),
        .any_valid (busy)
    );

`ifdef MUL_SHARE_STATS_EN
    logic [15:0] cnt_q [NUM_REQ];

    // Saturating grant counters; a clear beats a same-cycle grant.
    always_ff @(posedge ap_clk) begin
        if (ap_rst || stat_clr) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (take) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_idx == ID_W'(i) && cnt_q[i] != 16'hFFFF) begin
                    cnt_q[i] <= cnt_q[i] + 16'd1;
                end
            end
        end
    end

    // Flatten the counters onto the packed output.
    always_comb begin
        stat_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            stat_cnt[i*16 +: 16] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_example_mul_share_arb.sv
// Bench for example_mul_share_arb: directed scenarios plus random traffic,
// all checked against a queue-based reference model (MUL_SHARE_STATS_EN aware).
module tb_example_mul_share_arb;
    import example_mul_share_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int LAT     = LAT_DEFAULT;
    localparam int ID_W    = id_width(NUM_REQ);

    typedef struct {
        int p;
        int id;
        int cnt;
    } ent_t;

    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    logic busy;
`ifdef MUL_SHARE_STATS_EN
    logic                  stat_clr = 1'b0;
    logic [NUM_REQ*16-1:0] stat_cnt;
`endif

    example_mul_share_arb_if #(.NUM_REQ(NUM_REQ)) bus ();

    example_mul_share_arb #(
        .NUM_REQ (NUM_REQ),
        .LAT     (LAT)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .bus      (bus),
`ifdef MUL_SHARE_STATS_EN
        .stat_clr (stat_clr),
        .stat_cnt (stat_cnt),
`endif
        .busy     (busy)
    );

    always #5 ap_clk = ~ap_clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [NUM_REQ-1:0] pend;
    int                 op_a [NUM_REQ];
    int                 op_b [NUM_REQ];

    ent_t     mq [$];
    int       m_ptr;
    int       m_stat [NUM_REQ];
    int       grant_log [$];
    mul_rsp_t rsp_log [$];
    int       rsp_cyc [$];

    // Requester rule: a raised request stays up with stable operands until accepted.
    logic [NUM_REQ-1:0]       prev_v = '0;
    logic [NUM_REQ-1:0]       prev_r = '0;
    logic [NUM_REQ*A_W-1:0]   prev_a = '0;
    logic [NUM_REQ*B_W-1:0]   prev_b = '0;
    logic                     prev_rst = 1'b1;

    always @(posedge ap_clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!ap_rst && !prev_rst && prev_v[i] && !prev_r[i]) begin
                assert (bus.req_valid[i] &&
                        bus.req_a[i*A_W +: A_W] == prev_a[i*A_W +: A_W] &&
                        bus.req_b[i*B_W +: B_W] == prev_b[i*B_W +: B_W])
                else $error("[TB] requester %0d released or changed its request early", i);
            end
        end
        prev_v   <= bus.req_valid;
        prev_r   <= bus.req_ready;
        prev_a   <= bus.req_a;
        prev_b   <= bus.req_b;
        prev_rst <= ap_rst;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit modelValid();
        return (mq.size() > 0) && (mq[0].cnt == 0);
    endfunction

    // Round-robin winner from the model pointer, or -1 if none / stalled.
    function automatic int modelGrant();
        int idx;
        if (modelValid() && !bus.rsp_ready) return -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (m_ptr + k) % NUM_REQ;
            if (pend[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int randA();
        return int'($urandom_range(0, 16383)) - 8192;
    endfunction

    task automatic raiseReq(input int i, input int a, input int b);
        pend[i] = 1'b1;
        op_a[i] = a;
        op_b[i] = b;
    endtask

    task automatic applyStimulus();
        bus.req_valid = pend;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_a[i*A_W +: A_W] = A_W'(op_a[i]);
            bus.req_b[i*B_W +: B_W] = B_W'(op_b[i]);
        end
    endtask

    task automatic checkRsp();
        logic [P_W-1:0]        expP;
        logic [ID_W-1:0]       expId;
        logic [NUM_REQ*16-1:0] expStat;
        checkOutput("rsp_valid", bus.rsp_valid, modelValid());
        checkOutput("busy", busy, mq.size() > 0);
        if (modelValid()) begin
            expP  = P_W'(mq[0].p);
            expId = ID_W'(mq[0].id);
            checkOutput("rsp_p", bus.rsp_p, expP);
            checkOutput("rsp_id", bus.rsp_id, expId);
        end
        expStat = '0;
        for (int i = 0; i < NUM_REQ; i++) expStat[i*16 +: 16] = 16'(m_stat[i]);
`ifdef MUL_SHARE_STATS_EN
        checkOutput("stat_cnt", stat_cnt, expStat);
`endif
    endtask

    // One clock: drive after the falling edge, check ready, advance model, check outputs.
    task automatic stepCycle(input bit readyVal, input bit clrVal);
        int              g;
        logic [NUM_REQ-1:0] expReady;
        bit              obsV;
        logic [P_W-1:0]  obsP;
        logic [ID_W-1:0] obsId;
        bus.rsp_ready = readyVal;
`ifdef MUL_SHARE_STATS_EN
        stat_clr = clrVal;
`endif
        applyStimulus();
        #1;
        g = modelGrant();
        expReady = '0;
        if (g >= 0) expReady[g] = 1'b1;
        checkOutput("req_ready", bus.req_ready, expReady);
        obsV  = bus.rsp_valid;
        obsP  = bus.rsp_p;
        obsId = bus.rsp_id;
        @(posedge ap_clk);
        if (obsV && readyVal) begin
            rsp_log.push_back('{p: obsP, id: MAX_ID_W'(obsId)});
            rsp_cyc.push_back(cyc);
        end
        if (!(modelValid() && !readyVal)) begin
            if (modelValid()) void'(mq.pop_front());
            foreach (mq[j]) if (mq[j].cnt > 0) mq[j].cnt--;
            if (g >= 0) begin
                mq.push_back('{op_a[g] * op_b[g], g, LAT - 1});
                m_ptr = (g + 1) % NUM_REQ;
                grant_log.push_back(g);
                pend[g] = 1'b0;
            end
        end
        if (clrVal) begin
            foreach (m_stat[i]) m_stat[i] = 0;
        end else if (g >= 0 && m_stat[g] < 65535) begin
            m_stat[g]++;
        end
        cyc++;
        @(negedge ap_clk);
        checkRsp();
    endtask

    task automatic applyReset();
        ap_rst = 1'b1;
        pend   = '0;
        bus.rsp_ready = 1'b1;
`ifdef MUL_SHARE_STATS_EN
        stat_clr = 1'b0;
`endif
        applyStimulus();
        @(posedge ap_clk);
        mq.delete();
        m_ptr = 0;
        foreach (m_stat[i]) m_stat[i] = 0;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        checkRsp();
        checkOutput("rst_p", bus.rsp_p, '0);
        checkOutput("rst_id", bus.rsp_id, '0);
    endtask

    task automatic drain(input int maxCycles);
        for (int n = 0; n < maxCycles && (mq.size() > 0 || pend != '0); n++) begin
            stepCycle(1'b1, 1'b0);
        end
        checkOutput("drain_busy", busy, 1'b0);
    endtask

    task automatic clearLogs();
        grant_log.delete();
        rsp_log.delete();
        rsp_cyc.delete();
    endtask

    initial begin
        int raised [NUM_REQ];
        bit rdy;
        pend = '0;
        foreach (op_a[i]) begin op_a[i] = 0; op_b[i] = 0; end
        bus.rsp_ready = 1'b1;
        applyStimulus();
        @(negedge ap_clk);

        // 1: requester 0 alone, most negative a times largest b
        applyReset();
        clearLogs();
        raiseReq(0, -8192, 63);
        for (int c = 0; c < LAT + 2; c++) stepCycle(1'b1, 1'b0);
        checkOutput("t1_count", rsp_log.size(), 1);
        if (rsp_log.size() >= 1) begin
            checkOutput("t1_p", rsp_log[0].p, 20'h82000);
            checkOutput("t1_id", rsp_log[0].id, 0);
        end

        // 2: requester 3, most positive a, then a zero product
        clearLogs();
        raiseReq(3, 8191, 63);
        stepCycle(1'b1, 1'b0);
        raiseReq(3, -1, 0);
        drain(20);
        checkOutput("t2_count", rsp_log.size(), 2);
        if (rsp_log.size() >= 2) begin
            checkOutput("t2_p0", rsp_log[0].p, 20'h7DFC1);
            checkOutput("t2_id0", rsp_log[0].id, 3);
            checkOutput("t2_p1", rsp_log[1].p, 20'h00000);
        end

        // 3: all requesters busy from reset, two ops each
        applyReset();
        clearLogs();
        for (int i = 0; i < NUM_REQ; i++) begin
            raiseReq(i, randA(), int'($urandom_range(0, 63)));
            raised[i] = 1;
        end
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend[i] && raised[i] < 2) begin
                    raiseReq(i, randA(), int'($urandom_range(0, 63)));
                    raised[i]++;
                end
            end
            stepCycle(1'b1, 1'b0);
        end
        drain(20);
        checkOutput("t3_grants", grant_log.size(), 8);
        for (int k = 0; k < 8 && k < grant_log.size(); k++) begin
            checkOutput($sformatf("t3_grant%0d", k), grant_log[k], k % NUM_REQ);
        end
        checkOutput("t3_rsps", rsp_cyc.size(), 8);
        if (rsp_cyc.size() == 8) checkOutput("t3_span", rsp_cyc[7] - rsp_cyc[0], 7);

        // 4: continuous traffic with a 5-cycle output stall
        clearLogs();
        for (int c = 0; c < 21; c++) begin
            if (c < 11) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!pend[i]) raiseReq(i, randA(), int'($urandom_range(0, 63)));
                end
            end
            stepCycle(!(c >= 6 && c < 11), 1'b0);
        end
        drain(60);
        checkOutput("t4_count", rsp_log.size(), grant_log.size());

        // 5: reset with two ops in flight, then rr pointer back at 0
        applyReset();
        raiseReq(1, randA(), 5);
        raiseReq(2, randA(), 9);
        stepCycle(1'b1, 1'b0);
        stepCycle(1'b1, 1'b0);
        applyReset();
        clearLogs();
        for (int c = 0; c < LAT + 3; c++) stepCycle(1'b1, 1'b0);
        checkOutput("t5_stale", rsp_log.size(), 0);
        for (int i = 0; i < NUM_REQ; i++) raiseReq(i, randA(), int'($urandom_range(0, 63)));
        drain(40);
        if (grant_log.size() > 0) checkOutput("t5_first_grant", grant_log[0], 0);

`ifdef MUL_SHARE_STATS_EN
        // 6: grant counters and clear-over-grant priority
        applyReset();
        for (int n = 0; n < 3; n++) begin
            raiseReq(2, randA(), int'($urandom_range(0, 63)));
            stepCycle(1'b1, 1'b0);
        end
        drain(20);
        checkOutput("t6_cnt3", stat_cnt[2*16 +: 16], 16'd3);
        raiseReq(2, randA(), 1);
        stepCycle(1'b1, 1'b1);
        checkOutput("t6_clr", stat_cnt[2*16 +: 16], 16'd0);
        drain(20);
`endif

        // 7: random soak with random backpressure
        clearLogs();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 40)
                    raiseReq(i, randA(), int'($urandom_range(0, 63)));
            end
            rdy = ($urandom_range(0, 99) < 70);
            stepCycle(rdy, $urandom_range(0, 99) < 1);
        end
        drain(80);
        checkOutput("t7_count", rsp_log.size(), grant_log.size());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
